aha_sleep_hold_sequencer: RTL and testbench

- Initiator side of the CPU deep-sleep handshakes: SLEEPHOLDREQn/SLEEPHOLDACKn and PMU_WIC_EN_REQ/PMU_WIC_EN_ACK.
- On SLEEPDEEP it holds the CPU in sleep, hands wake detection to the WIC, and gates the CPU clock. On PMU_WAKEUP it reverses the sequence.
- Sits beside the platform controller. Its CPU_GCLK_EN output qualifies CPU_GCLK.

---
 rtl/aha_sleep_hold_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_aha_sleep_hold_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aha_sleep_hold_sequencer.sv
// aha_sleep_hold_sequencer
// Initiator side of the CPU deep-sleep handshakes. On SLEEPDEEP it requests a
// CPU sleep hold, hands wake detection to the WIC and gates the CPU clock;
// on PMU_WAKEUP it re-enables the clock, waits a settle period and then
// unwinds the WIC and hold handshakes in reverse order.
module aha_sleep_hold_sequencer #(
    parameter int ACK_TIMEOUT = 255,
    parameter int WAKE_SETTLE = 4,
    parameter int CNT_W       = 8
) (
    input  logic        MASTER_CLK,
    input  logic        PORESET,
    input  logic        SEQ_EN,
    input  logic        SLEEPDEEP,
    input  logic        LOCKUP,
    input  logic        SLEEPHOLDACKn,
    input  logic        PMU_WIC_EN_ACK,
    input  logic        PMU_WAKEUP,
    output logic        SLEEPHOLDREQn,
    output logic        PMU_WIC_EN_REQ,
    output logic        CPU_GCLK_EN,
    output logic        DEEP_SLEEP_ACTIVE,
    output logic        TIMEOUT_ERR,
    output logic [15:0] WAKE_COUNT,
    output logic [2:0]  SEQ_STATE
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HOLD_REQ = 3'd1,
        S_WIC_REQ  = 3'd2,
        S_GATED    = 3'd3,
        S_SETTLE   = 3'd4,
        S_WIC_REL  = 3'd5,
        S_HOLD_REL = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(WAKE_SETTLE - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic               hold_req_n_q, hold_req_n_d;
    logic               wic_en_req_q, wic_en_req_d;
    logic               gclk_en_q, gclk_en_d;
    logic               deep_active_q, deep_active_d;
    logic               timeout_err_q, timeout_err_d;
    logic [15:0]        wake_count_q, wake_count_d;
    logic               timeout;

    assign timeout = (cnt_q == TIMEOUT_VAL);

    // Next-state and next-output logic for the handshake sequencer.
    always_comb begin
        state_d       = state_q;
        hold_req_n_d  = hold_req_n_q;
        wic_en_req_d  = wic_en_req_q;
        gclk_en_d     = gclk_en_q;
        timeout_err_d = 1'b0;
        wake_count_d  = wake_count_q;

        case (state_q)
            S_IDLE: begin
                if (SEQ_EN && SLEEPDEEP && !LOCKUP && armed_q) begin
                    state_d      = S_HOLD_REQ;
                    hold_req_n_d = 1'b0;
                end
            end
            S_HOLD_REQ: begin
                // The CPU leaving sleep on its own is a clean abort.
                if (!SLEEPDEEP) begin
                    state_d      = S_HOLD_REL;
                    hold_req_n_d = 1'b1;
                end else if (!SLEEPHOLDACKn) begin
                    state_d      = S_WIC_REQ;
                    wic_en_req_d = 1'b1;
                end else if (timeout) begin
                    state_d       = S_HOLD_REL;
                    hold_req_n_d  = 1'b1;
                    timeout_err_d = 1'b1;
                end
            end
            S_WIC_REQ: begin
                // A wake racing the WIC ack wins: the clock is never gated.
                if (PMU_WAKEUP) begin
                    state_d      = S_WIC_REL;
                    wic_en_req_d = 1'b0;
                end else if (PMU_WIC_EN_ACK) begin
                    state_d   = S_GATED;
                    gclk_en_d = 1'b0;
                end else if (timeout) begin
                    state_d       = S_WIC_REL;
                    wic_en_req_d  = 1'b0;
                    timeout_err_d = 1'b1;
                end
            end
            S_GATED: begin
                if (PMU_WAKEUP) begin
                    state_d   = S_SETTLE;
                    gclk_en_d = 1'b1;
                    if (wake_count_q != 16'hFFFF) begin
                        wake_count_d = wake_count_q + 16'd1;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d      = S_WIC_REL;
                    wic_en_req_d = 1'b0;
                end
            end
            S_WIC_REL: begin
                if (!PMU_WIC_EN_ACK || timeout) begin
                    state_d       = S_HOLD_REL;
                    hold_req_n_d  = 1'b1;
                    timeout_err_d = PMU_WIC_EN_ACK;
                end
            end
            S_HOLD_REL: begin
                if (SLEEPHOLDACKn || timeout) begin
                    state_d       = S_IDLE;
                    timeout_err_d = !SLEEPHOLDACKn;
                end
            end
            default: begin
                state_d      = S_IDLE;
                hold_req_n_d = 1'b1;
                wic_en_req_d = 1'b0;
                gclk_en_d    = 1'b1;
            end
        endcase

        deep_active_d = (state_d == S_GATED);
    end

    // Shared timeout/settle counter and the re-entry guard.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        // Disarm after a completed sequence until the CPU is seen awake.
        if (!SLEEPDEEP) begin
            armed_d = 1'b1;
        end else if (state_q == S_HOLD_REL && state_d == S_IDLE) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    // State and registered outputs; reset leaves the CPU clock running.
    always_ff @(posedge MASTER_CLK or posedge PORESET) begin
        if (PORESET) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            armed_q       <= 1'b1;
            hold_req_n_q  <= 1'b1;
            wic_en_req_q  <= 1'b0;
            gclk_en_q     <= 1'b1;
            deep_active_q <= 1'b0;
            timeout_err_q <= 1'b0;
            wake_count_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            hold_req_n_q  <= hold_req_n_d;
            wic_en_req_q  <= wic_en_req_d;
            gclk_en_q     <= gclk_en_d;
            deep_active_q <= deep_active_d;
            timeout_err_q <= timeout_err_d;
            wake_count_q  <= wake_count_d;
        end
    end

    assign SLEEPHOLDREQn     = hold_req_n_q;
    assign PMU_WIC_EN_REQ    = wic_en_req_q;
    assign CPU_GCLK_EN       = gclk_en_q;
    assign DEEP_SLEEP_ACTIVE = deep_active_q;
    assign TIMEOUT_ERR       = timeout_err_q;
    assign WAKE_COUNT        = wake_count_q;
    assign SEQ_STATE         = state_q;

endmodule

// File: tb/tb_aha_sleep_hold_sequencer.sv
// Directed bench for aha_sleep_hold_sequencer: expected state transitions are
// queued with the stimulus and retired by a negedge monitor, which also
// checks the output/state invariants every cycle.
module tb_aha_sleep_hold_sequencer;

    localparam int ACK_TO = 8;
    localparam int SETTLE = 4;

    logic        MASTER_CLK;
    logic        PORESET;
    logic        SEQ_EN;
    logic        SLEEPDEEP;
    logic        LOCKUP;
    logic        SLEEPHOLDACKn;
    logic        PMU_WIC_EN_ACK;
    logic        PMU_WAKEUP;
    logic        SLEEPHOLDREQn;
    logic        PMU_WIC_EN_REQ;
    logic        CPU_GCLK_EN;
    logic        DEEP_SLEEP_ACTIVE;
    logic        TIMEOUT_ERR;
    logic [15:0] WAKE_COUNT;
    logic [2:0]  SEQ_STATE;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int tot_cnt  = 0;
    int tmo_pulses = 0;
    logic [2:0] exp_q[$];
    logic [2:0] last_state = 3'd0;

    aha_sleep_hold_sequencer #(
        .ACK_TIMEOUT(ACK_TO),
        .WAKE_SETTLE(SETTLE),
        .CNT_W(8)
    ) dut (
        .MASTER_CLK(MASTER_CLK),
        .PORESET(PORESET),
        .SEQ_EN(SEQ_EN),
        .SLEEPDEEP(SLEEPDEEP),
        .LOCKUP(LOCKUP),
        .SLEEPHOLDACKn(SLEEPHOLDACKn),
        .PMU_WIC_EN_ACK(PMU_WIC_EN_ACK),
        .PMU_WAKEUP(PMU_WAKEUP),
        .SLEEPHOLDREQn(SLEEPHOLDREQn),
        .PMU_WIC_EN_REQ(PMU_WIC_EN_REQ),
        .CPU_GCLK_EN(CPU_GCLK_EN),
        .DEEP_SLEEP_ACTIVE(DEEP_SLEEP_ACTIVE),
        .TIMEOUT_ERR(TIMEOUT_ERR),
        .WAKE_COUNT(WAKE_COUNT),
        .SEQ_STATE(SEQ_STATE)
    );

    initial MASTER_CLK = 1'b0;
    always #5 MASTER_CLK = ~MASTER_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt = tot_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge MASTER_CLK);
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (SEQ_STATE !== s && n < 100) begin
            @(negedge MASTER_CLK);
            n++;
        end
        check(tag, SEQ_STATE, s);
    endtask

    task automatic push_seq(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                            input logic [2:0] d, input int cnt);
        logic [2:0] v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < cnt; i++) exp_q.push_back(v[i]);
    endtask

    // Fast-ack full sleep/wake cycle used by the saturation test.
    task automatic wake_cycle();
        SLEEPDEEP = 1'b0;
        cyc(1);
        push_seq(3'd1, 3'd2, 3'd3, 3'd4, 4);
        push_seq(3'd5, 3'd6, 3'd0, 3'd0, 3);
        SLEEPDEEP      = 1'b1;
        SLEEPHOLDACKn  = 1'b0;
        PMU_WIC_EN_ACK = 1'b1;
        wait_state(3'd3, "sat_gated");
        cyc(2);
        PMU_WAKEUP = 1'b1;
        cyc(1);
        PMU_WAKEUP     = 1'b0;
        PMU_WIC_EN_ACK = 1'b0;
        SLEEPHOLDACKn  = 1'b1;
        wait_state(3'd0, "sat_idle");
    endtask

    // Scoreboard for state transitions plus per-cycle invariants.
    always @(negedge MASTER_CLK) begin
        if (!PORESET) begin
            if (SEQ_STATE !== last_state) begin
                if (exp_q.size() == 0) check("unexpected_state", SEQ_STATE, last_state);
                else check("state_seq", SEQ_STATE, exp_q.pop_front());
                last_state = SEQ_STATE;
            end
            if (TIMEOUT_ERR === 1'b1) tmo_pulses++;
            check("inv_gclk", CPU_GCLK_EN, SEQ_STATE != 3'd3);
            check("inv_deep", DEEP_SLEEP_ACTIVE, SEQ_STATE == 3'd3);
            check("inv_wicreq", PMU_WIC_EN_REQ, SEQ_STATE >= 3'd2 && SEQ_STATE <= 3'd4);
            check("inv_holdreq", SLEEPHOLDREQn, !(SEQ_STATE >= 3'd1 && SEQ_STATE <= 3'd5));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        PORESET        = 1'b1;
        SEQ_EN         = 1'b0;
        SLEEPDEEP      = 1'b0;
        LOCKUP         = 1'b0;
        SLEEPHOLDACKn  = 1'b1;
        PMU_WIC_EN_ACK = 1'b0;
        PMU_WAKEUP     = 1'b0;
        #1;
        check("rst_holdreqn", SLEEPHOLDREQn, 1);
        check("rst_wicreq", PMU_WIC_EN_REQ, 0);
        check("rst_gclk", CPU_GCLK_EN, 1);
        check("rst_deep", DEEP_SLEEP_ACTIVE, 0);
        check("rst_tmo", TIMEOUT_ERR, 0);
        check("rst_wakecnt", WAKE_COUNT, 0);
        check("rst_state", SEQ_STATE, 0);
        cyc(2);
        PORESET = 1'b0;
        cyc(1);

        // Full cycle with 3-cycle ack latencies.
        push_seq(3'd1, 3'd2, 3'd3, 3'd4, 4);
        push_seq(3'd5, 3'd6, 3'd0, 3'd0, 3);
        SEQ_EN    = 1'b1;
        SLEEPDEEP = 1'b1;
        wait_state(3'd1, "t1_hold_req");
        check("t1_reqn_low", SLEEPHOLDREQn, 0);
        cyc(3);
        SLEEPHOLDACKn = 1'b0;
        wait_state(3'd2, "t1_wic_req");
        check("t1_wicreq_high", PMU_WIC_EN_REQ, 1);
        cyc(3);
        PMU_WIC_EN_ACK = 1'b1;
        wait_state(3'd3, "t1_gated");
        check("t1_gclk_low", CPU_GCLK_EN, 0);
        cyc(20);
        PMU_WAKEUP = 1'b1;
        cyc(1);
        check("t1_settle", SEQ_STATE, 4);
        check("t1_gclk_back", CPU_GCLK_EN, 1);
        check("t1_wakecnt", WAKE_COUNT, 1);
        n = 0;
        while (PMU_WIC_EN_REQ === 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        check("t1_settle_len", n, SETTLE);
        PMU_WAKEUP     = 1'b0;
        PMU_WIC_EN_ACK = 1'b0;
        wait_state(3'd6, "t1_hold_rel");
        SLEEPHOLDACKn = 1'b1;
        wait_state(3'd0, "t1_idle");
        check("t1_no_timeout", tmo_pulses, 0);
        cyc(3);
        check("t1_no_reentry", SEQ_STATE, 0);

        // Abort: SLEEPDEEP drops two cycles into HOLD_REQ.
        SLEEPDEEP = 1'b0;
        cyc(1);
        push_seq(3'd1, 3'd6, 3'd0, 3'd0, 3);
        SLEEPDEEP = 1'b1;
        wait_state(3'd1, "t2_hold_req");
        cyc(2);
        SLEEPDEEP = 1'b0;
        cyc(1);
        check("t2_hold_rel", SEQ_STATE, 6);
        check("t2_reqn_high", SLEEPHOLDREQn, 1);
        wait_state(3'd0, "t2_idle");
        check("t2_no_timeout", tmo_pulses, 0);

        // Hold-ack timeout, then re-arm only after SLEEPDEEP toggles.
        push_seq(3'd1, 3'd6, 3'd0, 3'd0, 3);
        SLEEPDEEP = 1'b1;
        wait_state(3'd1, "t3_hold_req");
        n = 0;
        while (TIMEOUT_ERR !== 1'b1 && n < 30) begin
            cyc(1);
            n++;
        end
        // counter reaches ACK_TO after ACK_TO cycles; the registered pulse follows
        check("t3_tmo_latency", n, ACK_TO + 1);
        check("t3_tmo_state", SEQ_STATE, 6);
        check("t3_tmo_reqn", SLEEPHOLDREQn, 1);
        cyc(1);
        check("t3_tmo_single", TIMEOUT_ERR, 0);
        check("t3_tmo_idle", SEQ_STATE, 0);
        check("t3_tmo_count", tmo_pulses, 1);
        cyc(5);
        check("t3_no_reentry", SEQ_STATE, 0);
        SLEEPDEEP = 1'b0;
        cyc(1);
        push_seq(3'd1, 3'd2, 3'd5, 3'd6, 4);
        push_seq(3'd0, 3'd0, 3'd0, 3'd0, 1);
        SLEEPDEEP = 1'b1;
        wait_state(3'd1, "t3_rearm");

        // Wake and WIC ack arriving in the same WIC_REQ cycle.
        SLEEPHOLDACKn = 1'b0;
        wait_state(3'd2, "t4_wic_req");
        PMU_WAKEUP     = 1'b1;
        PMU_WIC_EN_ACK = 1'b1;
        cyc(1);
        check("t4_wic_rel", SEQ_STATE, 5);
        check("t4_gclk", CPU_GCLK_EN, 1);
        check("t4_wicreq", PMU_WIC_EN_REQ, 0);
        PMU_WAKEUP     = 1'b0;
        PMU_WIC_EN_ACK = 1'b0;
        wait_state(3'd6, "t4_hold_rel");
        SLEEPHOLDACKn = 1'b1;
        wait_state(3'd0, "t4_idle");
        check("t4_wakecnt", WAKE_COUNT, 1);

        // Asynchronous reset while GATED.
        SLEEPDEEP = 1'b0;
        cyc(1);
        push_seq(3'd1, 3'd2, 3'd3, 3'd0, 4);
        SLEEPDEEP      = 1'b1;
        SLEEPHOLDACKn  = 1'b0;
        PMU_WIC_EN_ACK = 1'b1;
        wait_state(3'd3, "t5_gated");
        #2;
        PORESET = 1'b1;
        #1;
        check("t5_state", SEQ_STATE, 0);
        check("t5_gclk", CPU_GCLK_EN, 1);
        check("t5_reqn", SLEEPHOLDREQn, 1);
        check("t5_wicreq", PMU_WIC_EN_REQ, 0);
        check("t5_deep", DEEP_SLEEP_ACTIVE, 0);
        check("t5_wakecnt", WAKE_COUNT, 0);
        SLEEPDEEP      = 1'b0;
        SLEEPHOLDACKn  = 1'b1;
        PMU_WIC_EN_ACK = 1'b0;
        #1;
        PORESET = 1'b0;
        cyc(2);

        // Saturating wake counter.
        force dut.wake_count_q = 16'hFFFE;
        #1;
        release dut.wake_count_q;
        #1;
        check("t6_preload", WAKE_COUNT, 16'hFFFE);
        wake_cycle();
        check("t6_wake_ffff", WAKE_COUNT, 16'hFFFF);
        wake_cycle();
        check("t6_wake_sat", WAKE_COUNT, 16'hFFFF);

        // LOCKUP and SEQ_EN both block entry.
        SLEEPDEEP = 1'b0;
        LOCKUP    = 1'b1;
        cyc(1);
        SLEEPDEEP = 1'b1;
        cyc(10);
        check("t6_lockup_idle", SEQ_STATE, 0);
        check("t6_lockup_reqn", SLEEPHOLDREQn, 1);
        LOCKUP = 1'b0;
        SEQ_EN = 1'b0;
        cyc(3);
        check("t6_seqen_idle", SEQ_STATE, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
